irq_dispatch: RTL and testbench
===============================

// Module: irq_dispatch
// PURPOSE
//  Sequential consumer of priority selection: latches interrupt events, picks the highest-priority
//  eligible pending source and hands its id to the core over a valid/ready handshake. Tracks the
//  in-service level until the core signals completion. Sits between interrupt sources and core.
// PARAMETERS
//  Width      8  number of interrupt sources
//  PrioWidth  8  priority value width; larger value = more urgent; prio 0 never dispatched
//  NestDepth  4  in-service stack depth (used only with IRQ_DISPATCH_NEST_EN)
// PORTS
//  clk         in   1                   single clock, rising edge
//  reset_n     in   1                   asynchronous, active-low reset
//  irq         in   Width               level event per source; sampled each cycle, sets pending
//  prio        in   PrioWidth x Width   per-source priority, static while pending
//  disp_valid  out  1                   dispatch offer valid
//  disp_ready  in   1                   core accepts offer when high with disp_valid
//  disp_id     out  $clog2(Width)       id of offered source
//  disp_prio   out  PrioWidth           priority of offered source
//  disp_done   in   1                   one-cycle pulse: core finished current handler
//  busy        out  1                   at least one handler in service
//  nest_depth  out  $clog2(NestDepth+1) handlers in service (0/1 without nesting)
// BEHAVIOUR
//  - Reset: pend_q=0, disp_valid=0, disp_id=0, disp_prio=0, busy=0, nest_depth=0, state IDLE.
//  - Pending: pend_q[i] <= irq[i] | pend_q[i] & ~clr[i]; clr set for accepted id. Set wins over
//    clear for the same source in the same cycle (event retained).
//  - Eligible: pend_q[i] && prio[i] > thr; thr = 0 when idle, else top-of-stack priority.
//    Winner = max prio; ties -> lowest index.
//  - Latency: pending set in cycle N -> disp_valid high in cycle N+2 (pend reg + offer reg).
//  - FSM: IDLE --eligible--> OFFER; OFFER --valid&ready--> BUSY (push disp_prio, clear pending);
//    BUSY --disp_done, depth becomes 0--> IDLE; BUSY --eligible & nesting allowed--> OFFER.
//  - Handshake: once disp_valid rises, disp_id/disp_prio stay stable until accepted; no
//    withdrawal or replacement even if a higher source arrives. disp_valid drops the cycle
//    after acceptance.
//  - disp_done with depth 0 ignored. disp_done and acceptance in same cycle: pop first, then push;
//    depth unchanged.
//  - Reset mid-offer or mid-service: all state cleared immediately, pending lost.
// CONFIGURATION
//  IRQ_DISPATCH_NEST_EN defined: NestDepth-entry priority stack; in BUSY a new offer is made when
//    eligible prio > top and depth < NestDepth; disp_done pops; full stack blocks offers.
//  Not defined: single in-service register; no offer while busy; nest_depth is 0 or 1.
// STRUCTURE
//  irq_pkg: IrqId, IrqPrio typedefs, DispState enum {IDLE, OFFER, BUSY}.
//  Sub-module irq_select: combinational masked max-priority index finder (Width, PrioWidth),
//  outputs found flag, id and prio; instantiated once.
// TESTING
//  1 irq[3]=1 one cycle, prio[3]=5, ready=1 -> valid 2 cycles later, id=3, prio=5; pend[3] cleared.
//  2 irq[2],irq[6] same cycle, prio 7/7 -> id=2 first; after done, id=6 offered.
//  3 ready=0 held 10 cycles, irq[1] prio 9 arrives while id=4 prio 3 offered -> id stays 4 until ready.
//  4 NEST_EN: in service prio 4, irq[5] prio 8 -> offered, depth 2; prio 2 source waits until depth 0.
//  5 no NEST_EN: busy, higher irq arrives -> disp_valid stays 0 until disp_done, then offered.
//  6 reset_n low during OFFER -> disp_valid=0, busy=0, pend_q=0 same cycle (async).

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types for the interrupt dispatcher: id/priority widths at default sizing and FSM states.
package irq_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefPrioWidth = 8;

    typedef logic [$clog2(DefWidth)-1:0] IrqId;
    typedef logic [DefPrioWidth-1:0]     IrqPrio;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        BUSY
    } DispState;

endpackage

// File: rtl/irq_select.sv
// Combinational finder: highest priority among masked sources strictly above thr; ties go to lowest index.
module irq_select #(
    parameter int unsigned Width     = 8,
    parameter int unsigned PrioWidth = 8
) (
    input  logic [Width-1:0]                mask,
    input  logic [Width-1:0][PrioWidth-1:0] prio,
    input  logic [PrioWidth-1:0]            thr,
    output logic                            found,
    output logic [$clog2(Width)-1:0]        id,
    output logic [PrioWidth-1:0]            best
);

    localparam int unsigned IdW = $clog2(Width);

    always_comb begin
        found = 1'b0;
        id    = '0;
        best  = '0;
        // Strict compare keeps the earliest index on equal priorities.
        for (int unsigned i = 0; i < Width; i++) begin
            if (mask[i] && (prio[i] > thr) && (!found || (prio[i] > best))) begin
                found = 1'b1;
                id    = i[IdW-1:0];
                best  = prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: latches events, offers the best eligible source over valid/ready, tracks service depth.
// Optional nesting stack enabled by defining IRQ_DISPATCH_NEST_EN.
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int unsigned Width     = 8,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned NestDepth = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [Width-1:0]                irq,
    input  logic [Width-1:0][PrioWidth-1:0] prio,
    output logic                            disp_valid,
    input  logic                            disp_ready,
    output logic [$clog2(Width)-1:0]        disp_id,
    output logic [PrioWidth-1:0]            disp_prio,
    input  logic                            disp_done,
    output logic                            busy,
    output logic [$clog2(NestDepth+1)-1:0]  nest_depth
);

    localparam int unsigned IdW  = $clog2(Width);
    localparam int unsigned DepW = $clog2(NestDepth+1);
`ifdef IRQ_DISPATCH_NEST_EN
    localparam int unsigned StackDepth = NestDepth;
`else
    localparam int unsigned StackDepth = 1;
`endif

    DispState             state_q, state_d;
    logic [Width-1:0]     pend_q, clr;
    logic [DepW-1:0]      depth_q, depth_d;
    logic [PrioWidth-1:0] stack_q [StackDepth];
    logic [IdW-1:0]       id_q;
    logic [PrioWidth-1:0] prio_q;
    logic [PrioWidth-1:0] top_prio;
    logic                 accept, pop, load;
    int unsigned          wr_idx;
    logic                 sel_found;
    logic [IdW-1:0]       sel_id;
    logic [PrioWidth-1:0] sel_prio;

    irq_select #(
        .Width     (Width),
        .PrioWidth (PrioWidth)
    ) u_select (
        .mask  (pend_q),
        .prio  (prio),
        .thr   (top_prio),
        .found (sel_found),
        .id    (sel_id),
        .best  (sel_prio)
    );

    always_comb begin
        top_prio = '0;
        for (int unsigned i = 0; i < StackDepth; i++) begin
            if (32'(depth_q) == i + 1) top_prio = stack_q[i];
        end
    end

    assign accept = (state_q == OFFER) && disp_ready;
    assign pop    = disp_done && (depth_q != '0);

    // Simultaneous pop and push overwrites the top entry in place.
    always_comb begin
        clr     = '0;
        wr_idx  = 32'(depth_q);
        depth_d = depth_q;
        if (accept) clr[id_q] = 1'b1;
        if (pop) wr_idx = 32'(depth_q) - 1;
        if (accept && !pop) depth_d = depth_q + 1'b1;
        else if (!accept && pop) depth_d = depth_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = OFFER;
                    load    = 1'b1;
                end
            end
            OFFER: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                if (pop && (depth_q == DepW'(1))) begin
                    state_d = IDLE;
                end else if (!pop && sel_found && (32'(depth_q) < StackDepth)) begin
                    state_d = OFFER;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            depth_q <= '0;
            id_q    <= '0;
            prio_q  <= '0;
            for (int unsigned i = 0; i < StackDepth; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= irq | (pend_q & ~clr);
            depth_q <= depth_d;
            if (load) begin
                id_q   <= sel_id;
                prio_q <= sel_prio;
            end
            for (int unsigned i = 0; i < StackDepth; i++) begin
                if (accept && (i == wr_idx)) stack_q[i] <= prio_q;
            end
        end
    end

    assign disp_valid = (state_q == OFFER);
    assign disp_id    = id_q;
    assign disp_prio  = prio_q;
    assign busy       = (depth_q != '0);
    assign nest_depth = depth_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: directed stimulus pushes expected offers, a monitor checks each acceptance.
module tb_irq_dispatch;
    import irq_pkg::*;

    typedef struct packed {
        IrqId   id;
        IrqPrio prio;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [7:0]      irq;
    logic [7:0][7:0] prio;
    logic            disp_valid, disp_ready, disp_done, busy;
    IrqId            disp_id;
    IrqPrio          disp_prio;
    logic [2:0]      nest_depth;

    int   tests = 0;
    int   fails = 0;
    int   acc_cnt = 0;
    exp_t sb[$];

    irq_dispatch #(
        .Width     (8),
        .PrioWidth (8),
        .NestDepth (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .prio       (prio),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_id    (disp_id),
        .disp_prio  (disp_prio),
        .disp_done  (disp_done),
        .busy       (busy),
        .nest_depth (nest_depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && disp_valid && disp_ready) begin
            acc_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_accept", 32'(disp_id), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("accept_id", 32'(disp_id), 32'(e.id));
                check("accept_prio", 32'(disp_prio), 32'(e.prio));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input string name);
        for (int k = 0; k < 50 && acc_cnt < target; k++) tick();
        check(name, 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic pulse_done();
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && busy; k++) begin
            pulse_done();
            tick();
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        reset_n    = 1'b0;
        irq        = '0;
        prio       = '0;
        disp_ready = 1'b0;
        disp_done  = 1'b0;
        #12;
        check("rst_valid", 32'(disp_valid), 32'd0);
        check("rst_id", 32'(disp_id), 32'd0);
        check("rst_prio", 32'(disp_prio), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_depth", 32'(nest_depth), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: single event, two-cycle latency
        disp_ready = 1'b1;
        prio[3] = 8'd5;
        irq = 8'h08;
        sb.push_back('{id: 3'd3, prio: 8'd5});
        tick();
        irq = '0;
        check("t1_lat_n1", 32'(disp_valid), 32'd0);
        tick();
        check("t1_lat_n2", 32'(disp_valid), 32'd1);
        tick();
        check("t1_drop", 32'(disp_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_depth", 32'(nest_depth), 32'd1);
        check("t1_pend_clr", 32'(dut.pend_q[3]), 32'd0);
        pulse_done();
        check("t1_done_busy", 32'(busy), 32'd0);
        tick();
        check("t1_no_reoffer", 32'(disp_valid), 32'd0);

        // 2: equal priorities, lowest index first
        base = acc_cnt;
        prio[2] = 8'd7;
        prio[6] = 8'd7;
        irq = 8'h44;
        sb.push_back('{id: 3'd2, prio: 8'd7});
        sb.push_back('{id: 3'd6, prio: 8'd7});
        tick();
        irq = '0;
        wait_acc(base + 1, "t2_first_timeout");
        check("t2_depth", 32'(nest_depth), 32'd1);
        pulse_done();
        wait_acc(base + 2, "t2_second_timeout");
        drain();

        // 3: offer held stable while ready low
        base = acc_cnt;
        disp_ready = 1'b0;
        prio[4] = 8'd3;
        prio[1] = 8'd9;
        sb.push_back('{id: 3'd4, prio: 8'd3});
        sb.push_back('{id: 3'd1, prio: 8'd9});
        irq = 8'h10;
        tick();
        irq = 8'h02;
        tick();
        irq = '0;
        for (int k = 0; k < 10; k++) begin
            check("t3_hold_valid", 32'(disp_valid), 32'd1);
            check("t3_hold_id", 32'(disp_id), 32'd4);
            check("t3_hold_prio", 32'(disp_prio), 32'd3);
            tick();
        end
        disp_ready = 1'b1;
        wait_acc(base + 1, "t3_first_timeout");
`ifndef IRQ_DISPATCH_NEST_EN
        pulse_done();
`endif
        wait_acc(base + 2, "t3_second_timeout");
        drain();

`ifdef IRQ_DISPATCH_NEST_EN
        // 4: nested preemption, low source waits for full unwind
        base = acc_cnt;
        prio[0] = 8'd4;
        irq = 8'h01;
        sb.push_back('{id: 3'd0, prio: 8'd4});
        tick();
        irq = '0;
        wait_acc(base + 1, "t4_first_timeout");
        prio[5] = 8'd8;
        prio[2] = 8'd2;
        irq = 8'h24;
        sb.push_back('{id: 3'd5, prio: 8'd8});
        sb.push_back('{id: 3'd2, prio: 8'd2});
        tick();
        irq = '0;
        wait_acc(base + 2, "t4_nest_timeout");
        check("t4_depth2", 32'(nest_depth), 32'd2);
        pulse_done();
        for (int k = 0; k < 4; k++) begin
            check("t4_low_blocked", 32'(disp_valid), 32'd0);
            tick();
        end
        check("t4_depth1", 32'(nest_depth), 32'd1);
        pulse_done();
        wait_acc(base + 3, "t4_low_timeout");
        drain();
`else
        // 5: no preemption while busy
        base = acc_cnt;
        prio[0] = 8'd2;
        irq = 8'h01;
        sb.push_back('{id: 3'd0, prio: 8'd2});
        tick();
        irq = '0;
        wait_acc(base + 1, "t5_first_timeout");
        prio[7] = 8'd10;
        irq = 8'h80;
        sb.push_back('{id: 3'd7, prio: 8'd10});
        tick();
        irq = '0;
        for (int k = 0; k < 5; k++) begin
            check("t5_blocked", 32'(disp_valid), 32'd0);
            tick();
        end
        check("t5_depth", 32'(nest_depth), 32'd1);
        pulse_done();
        wait_acc(base + 2, "t5_second_timeout");
        drain();
`endif

        // 6: asynchronous reset during an offer
        disp_ready = 1'b0;
        prio[3] = 8'd5;
        irq = 8'h08;
        tick();
        irq = '0;
        tick();
        check("t6_offer_up", 32'(disp_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(disp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_pend", 32'(dut.pend_q), 32'd0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        disp_ready = 1'b1;
        tick();
        tick();
        check("t6_pend_lost", 32'(disp_valid), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
